// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock, LSB first.
// Valid/ready handshake on operand intake and result delivery; borrow/overflow/zero flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             br_next;
  logic             a_msb;
  logic             b_msb;
  logic             ai;
  logic             bi;
  logic             d;
  logic             last_bit;

  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  assign ai       = a_sh[0];
  assign bi       = b_sh[0];
  assign d        = ai ^ bi ^ br;
  assign br_next  = sub_borrow(ai, bi, br);
  assign res_next = {d, res[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Handshake/status outputs depend on the state register only.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN) || (state == DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = RUN;
        else          state_next = IDLE;
      end
      RUN: begin
        if (last_bit) state_next = DONE;
        else          state_next = RUN;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
        else           state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand shifting, borrow chain and result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= {WIDTH{1'b0}};
      b_sh     <= {WIDTH{1'b0}};
      res      <= {WIDTH{1'b0}};
      cnt      <= {CW{1'b0}};
      br       <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            br    <= 1'b0;
            cnt   <= {CW{1'b0}};
          end
        end
        RUN: begin
          a_sh <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh <= {1'b0, b_sh[WIDTH-1:1]};
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // The final bit's d is the result MSB, so flags come from res_next.
          if (last_bit) begin
            diff     <= res_next;
            borrow   <= br_next;
            overflow <= (a_msb ^ b_msb) & (d ^ a_msb);
            zero     <= (res_next == {WIDTH{1'b0}});
          end
        end
        DONE: begin
          res <= res;
        end
        default: begin
          res <= res;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus a random regression
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;
  logic             busy;

  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] prev_diff;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one subtraction, check latency/result/flags, hold DONE for 'hold' cycles, then drain.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input int hold, input bit junk);
    logic [WIDTH-1:0] ed;
    logic             eb;
    logic             eo;
    logic             ez;
    int               sd;
    int               k;
    ed = av - bv;
    eb = (av < bv);
    sd = int'($signed(av)) - int'($signed(bv));
    eo = (sd > 127) || (sd < -128);
    ez = (ed == 8'd0);

    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);

    in_valid = 1'b1;
    a = av;
    b = bv;
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    chk("diff_held_in_run", 32'(diff), 32'(prev_diff));

    k = 0;
    while (!out_valid && k < 2 * WIDTH) begin
      if (junk) begin
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h11;
      end
      tick();
      k++;
    end
    chk("latency", 32'(k), 32'(WIDTH));
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow", 32'(borrow), 32'(eb));
    chk("overflow", 32'(overflow), 32'(eo));
    chk("zero", 32'(zero), 32'(ez));

    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h11;
      end
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_flags", {29'd0, borrow, overflow, zero}, {29'd0, eb, eo, ez});
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("idle_diff_held", 32'(diff), 32'(ed));
    prev_diff = ed;
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    bit               seen_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    prev_diff = 8'h00;

    run_op(8'h05, 8'h03, 0, 1'b0);
    run_op(8'h03, 8'h05, 1, 1'b0);
    run_op(8'h80, 8'h01, 0, 1'b0);
    run_op(8'h7F, 8'hFF, 2, 1'b0);
    run_op(8'h5A, 8'h5A, 5, 1'b1);
    run_op(8'h22, 8'h20, 0, 1'b0);

    // Abort an operation with reset on its third RUN cycle.
    in_valid = 1'b1;
    a = 8'h10;
    b = 8'h01;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_flags", {29'd0, borrow, overflow, zero}, 32'd0);
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_out_valid", 32'(seen_valid), 32'd0);
    prev_diff = 8'h00;
    run_op(8'h10, 8'h01, 0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
